// File: rtl/dc_ipu_pipe_divider.sv
// dc_ipu_pipe_divider
//   Fully pipelined restoring integer divider. Accepts one operation per cycle
//   and resolves BITS_PER_STAGE quotient bits on every pipeline advance.
//   Signed operations divide magnitudes and fix the signs at the output.
//
// Ports
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   clr              synchronous flush of every in-flight operation
//   in_valid/ready   input handshake; in_ready = (~out_valid | out_ready) & ~clr
//   in_sgn           1 = signed two's-complement, 0 = unsigned
//   in_tag           sideband tag returned with the result
//   a, b             dividend (A_WIDTH), divisor (B_WIDTH)
//   out_valid/ready  output handshake; outputs hold while stalled
//   q, r             quotient (A_WIDTH), remainder (B_WIDTH)
//   out_tag          tag captured at acceptance
//   dz, ovf          divide-by-zero and signed-overflow flags
module dc_ipu_pipe_divider #(
    parameter int unsigned A_WIDTH        = 8,
    parameter int unsigned B_WIDTH        = 8,
    parameter int unsigned BITS_PER_STAGE = 2,
    parameter int unsigned TAG_WIDTH      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sgn,
    input  logic [TAG_WIDTH-1:0] in_tag,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [A_WIDTH-1:0]   q,
    output logic [B_WIDTH-1:0]   r,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 dz,
    output logic                 ovf
);

    localparam int unsigned L  = (A_WIDTH + BITS_PER_STAGE - 1) / BITS_PER_STAGE;
    localparam int unsigned QW = L * BITS_PER_STAGE;
    localparam logic [A_WIDTH-1:0] A_MIN = {1'b1, {(A_WIDTH-1){1'b0}}};

    logic adv;

    // Stage k holds the operation after k*BITS_PER_STAGE quotient bits.
    // saq is the combined dividend/quotient shift register.
    logic [L-1:0]                sv;
    logic [L-1:0][QW-1:0]        saq;
    logic [L-1:0][B_WIDTH-1:0]   srem;
    logic [L-1:0][B_WIDTH-1:0]   sdiv;
    logic [L-1:0]                sneg_q;
    logic [L-1:0]                sneg_r;
    logic [L-1:0]                sdz;
    logic [L-1:0]                sovf;
    logic [L-1:0][TAG_WIDTH-1:0] stag;

    logic [L-1:0][QW-1:0]        naq;
    logic [L-1:0][B_WIDTH-1:0]   nrem;

    logic                        b_zero;
    logic                        a_neg;
    logic                        b_neg;
    logic                        ovf_in;
    logic [A_WIDTH-1:0]          a_mag;
    logic [B_WIDTH-1:0]          b_mag;
    logic [A_WIDTH-1:0]          q_mag;
    logic [B_WIDTH-1:0]          r_mag;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv & ~clr;

    // Entry: reduce operands to magnitudes. For b == 0 the dividend is kept
    // raw and unsigned; dividing by a zero divisor then yields an all-ones
    // quotient and leaves the low B_WIDTH dividend bits as remainder, which
    // is exactly the divide-by-zero result without any output override.
    always_comb begin
        b_zero = (b == '0);
        a_neg  = in_sgn & a[A_WIDTH-1] & ~b_zero;
        b_neg  = in_sgn & b[B_WIDTH-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        ovf_in = in_sgn & (a == A_MIN) & (b == '1);
    end

    // Restoring division steps between consecutive stages.
    always_comb begin
        logic [QW-1:0]      aq;
        logic [B_WIDTH-1:0] rm;
        logic [B_WIDTH:0]   sh;
        aq   = '0;
        rm   = '0;
        sh   = '0;
        naq  = '0;
        nrem = '0;
        for (int unsigned k = 0; k < L; k++) begin
            aq = saq[k];
            rm = srem[k];
            for (int unsigned i = 0; i < BITS_PER_STAGE; i++) begin
                sh = {rm, aq[QW-1]};
                if (sh >= {1'b0, sdiv[k]}) begin
                    sh = sh - {1'b0, sdiv[k]};
                    aq = {aq[QW-2:0], 1'b1};
                end else begin
                    aq = {aq[QW-2:0], 1'b0};
                end
                rm = sh[B_WIDTH-1:0];
            end
            naq[k]  = aq;
            nrem[k] = rm;
        end
    end

    always_comb begin
        q_mag = naq[L-1][A_WIDTH-1:0];
        r_mag = nrem[L-1];
    end

    // Valid bits: cleared by reset and clr, otherwise shift on adv.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sv        <= '0;
            out_valid <= 1'b0;
        end else if (clr) begin
            sv        <= '0;
            out_valid <= 1'b0;
        end else if (adv) begin
            sv[0] <= in_valid;
            for (int unsigned k = 1; k < L; k++) begin
                sv[k] <= sv[k-1];
            end
            out_valid <= sv[L-1];
        end
    end

    // Datapath: moves only on adv, so outputs hold while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            saq     <= '0;
            srem    <= '0;
            sdiv    <= '0;
            sneg_q  <= '0;
            sneg_r  <= '0;
            sdz     <= '0;
            sovf    <= '0;
            stag    <= '0;
            q       <= '0;
            r       <= '0;
            out_tag <= '0;
            dz      <= 1'b0;
            ovf     <= 1'b0;
        end else if (adv) begin
            saq[0]    <= QW'(a_mag);
            srem[0]   <= '0;
            sdiv[0]   <= b_mag;
            sneg_q[0] <= a_neg ^ b_neg;
            sneg_r[0] <= a_neg;
            sdz[0]    <= b_zero;
            sovf[0]   <= ovf_in;
            stag[0]   <= in_tag;
            for (int unsigned k = 1; k < L; k++) begin
                saq[k]    <= naq[k-1];
                srem[k]   <= nrem[k-1];
                sdiv[k]   <= sdiv[k-1];
                sneg_q[k] <= sneg_q[k-1];
                sneg_r[k] <= sneg_r[k-1];
                sdz[k]    <= sdz[k-1];
                sovf[k]   <= sovf[k-1];
                stag[k]   <= stag[k-1];
            end
            q       <= sneg_q[L-1] ? -q_mag : q_mag;
            r       <= sneg_r[L-1] ? -r_mag : r_mag;
            out_tag <= stag[L-1];
            dz      <= sdz[L-1];
            ovf     <= sovf[L-1];
        end
    end

endmodule

// File: doc/dc_ipu_pipe_divider.md
Name: dc_ipu_pipe_divider

Overview:
- Parametrised, fully pipelined integer divider for the IPU arithmetic library; successor to the single-issue array divider.
- Accepts one division per cycle over a valid/ready handshake and resolves BITS_PER_STAGE quotient bits per pipeline stage.
- Adds a per-transaction signed/unsigned mode, a tag passthrough, divide-by-zero and signed-overflow flags, and a synchronous flush.
- Sits between the scaler coefficient generator and its consumers.

Parameters:
A_WIDTH, 8, dividend and quotient width (>=2)
B_WIDTH, 8, divisor and remainder width (>=2, <=A_WIDTH)
BITS_PER_STAGE, 2, quotient bits resolved per pipeline stage (1..A_WIDTH)
TAG_WIDTH, 4, width of the sideband tag carried with each operation

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
clr  in  1  synchronous flush of all in-flight operations
in_valid  in  1  input operation valid
in_ready  out  1  block can accept an operation
in_sgn  in  1  1 = signed two's-complement division, 0 = unsigned
in_tag  in  TAG_WIDTH  sideband tag, returned unchanged with the result
a  in  A_WIDTH  dividend
b  in  B_WIDTH  divisor
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
q  out  A_WIDTH  quotient
r  out  B_WIDTH  remainder
out_tag  out  TAG_WIDTH  tag of this result
dz  out  1  divide-by-zero flag for this result
ovf  out  1  signed overflow flag for this result

Behaviour:
- Latency L = ceil(A_WIDTH/BITS_PER_STAGE) cycles from the in_transfer edge to out_valid=1, given no stall. Defaults: L=4.
- Stage count = L. Each stage holds valid, partial remainder, partial quotient, sign bits, tag, dz and ovf.
- Stall model:
  - adv = ~out_valid | out_ready.
  - The whole pipe shifts only when adv=1.
  - in_ready = adv & ~clr. No combinational path from in_valid to in_ready.
  - Bubbles are not collapsed. Throughput is 1 op/cycle with out_ready held high.
- Transfers: in_transfer = in_valid & in_ready; out_transfer = out_valid & out_ready.
- While out_valid=1 and out_ready=0, the outputs q, r, out_tag, dz and ovf stay stable.
- Unsigned results: q = a / b, r = a mod b. Arithmetic is restoring division on the magnitude.
- Signed results (in_sgn=1):
  - Operands are negated to magnitudes at entry.
  - The quotient truncates toward zero.
  - q is negated when sign(a) != sign(b).
  - r takes the sign of a.
  - r always satisfies |r| < |b|.
- Divide by zero (b=0), in either mode: q = all ones, r = a[B_WIDTH-1:0], dz=1, ovf=0.
- Signed overflow (in_sgn=1, a = most negative value, b = all ones i.e. -1): q = a, r = 0, ovf=1, dz=0.
- In all other cases dz=0 and ovf=0.
- Ordering: results leave in acceptance order. out_tag equals the in_tag captured at acceptance.
- clr:
  - When clr=1 at an edge, all stage valids clear and out_valid goes to 0 on that edge.
  - in_ready is 0 while clr=1, so no operation is accepted in that cycle.
  - Data registers need not clear.
- reset, asserted at any time, including mid-operation:
  - Immediately forces all stage valids, out_valid, q, r, out_tag, dz and ovf to 0.
  - in_ready is 1 once reset deasserts and clr=0.
- Simultaneous out_transfer and in_transfer in the same cycle is legal and required for full throughput.
- The datapath carries no state between operations. Signed and unsigned operations may interleave every cycle.

Test Plan:
- Unsigned, default params: a=255, b=15, sgn=0, tag=3, out_ready=1 -> 4 cycles later out_valid=1, q=17, r=0, out_tag=3, dz=0.
- Signed: a=0xF9 (-7), b=0x02 -> q=0xFD (-3), r=0xFF (-1). Then a=0x07, b=0xFE (-2) -> q=0xFD, r=0x01.
- Edge cases:
  - a=50, b=0, sgn=0 -> q=0xFF, r=50, dz=1.
  - a=0x80, b=0xFF, sgn=1 -> q=0x80, r=0, ovf=1.
- Back-to-back stream of the 11 pairs (15/1, 10/5, 2/2, 12/3, 12/4, 255/15, 150/10, 16/128, 50/40, 21/3, 27/9), tags 0..10, over 64 cycles:
  - in_valid low in cycles 10-11; out_ready low in cycles 5, 7, 8, 10.
  - Required: every result is correct, in order, with the matching tag; nothing is lost or duplicated; outputs are stable while stalled.
- Flush: with 3 ops in flight, assert clr for 1 cycle -> in_ready=0 during that cycle, out_valid=0 afterwards, and none of the 3 results ever appears. The next accepted op completes correctly after L cycles.
- Reset mid-operation: assert reset asynchronously with the pipe full and out_ready=0 -> out_valid, q, r, out_tag, dz and ovf drop to 0 before the next edge. After release, in_ready=1 and a new op 150/10 gives q=15, r=0.
